// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving the CPU data port (M0) and the UART load/DMA
// engine (M1) shared access to the single-port data memory. An owner may lock the memory
// across transfers, capped at BURST_MAX grants while the other master waits.
// Optional build macro DMEM_ARB_LOCK_TIMEOUT_EN: force-release a lock held with no request
// for TIMEOUT cycles and pulse lock_err. Without it the lock is honoured indefinitely.
module dmem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_rd,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_rd,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner,
    output logic          lock_err
);

    localparam int unsigned BcW = $clog2(BURST_MAX) + 1;
    localparam logic [BcW-1:0] BurstLast = BcW'(BURST_MAX - 1);

    // Encoding doubles as the owner output.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    if (BURST_MAX < 1 || TIMEOUT < 1) begin : g_param_check
        $error("dmem_arbiter: BURST_MAX and TIMEOUT must be at least 1");
    end

    state_e         state_q;
    logic           rr_last_q;    // index of the master that most recently took ownership
    logic [BcW-1:0] burst_cnt_q;
    logic           m0_rvalid_q;
    logic           m1_rvalid_q;

    logic   gnt0;
    logic   gnt1;
    logic   elig0;                // request not barred by a forced lock release
    logic   elig1;
    logic   own_is1;
    logic   own_req;
    logic   own_lock;
    logic   own_gnt;
    logic   oth_req;
    state_e st_oth;
    logic   force_rel;

    assign gnt0 = (state_q == StOwn0) & m0_req;
    assign gnt1 = (state_q == StOwn1) & m1_req;

`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    logic [ToW-1:0] idle_lock_cnt_q;
    logic           blk0_q;
    logic           blk1_q;
    logic           lock_err_q;
    logic           idle_lock;

    assign idle_lock = (state_q != StIdle) & own_lock & ~own_req;
    assign force_rel = idle_lock & (idle_lock_cnt_q == ToW'(TIMEOUT - 1));
    assign elig0     = m0_req & ~blk0_q;
    assign elig1     = m1_req & ~blk1_q;
    assign lock_err  = lock_err_q;

    // Idle-lock watchdog; a released owner stays barred until it drops its lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_lock_cnt_q <= '0;
            blk0_q          <= 1'b0;
            blk1_q          <= 1'b0;
            lock_err_q      <= 1'b0;
        end else begin
            lock_err_q <= force_rel;
            if (force_rel || !idle_lock) begin
                idle_lock_cnt_q <= '0;
            end else begin
                idle_lock_cnt_q <= idle_lock_cnt_q + 1'b1;
            end
            blk0_q <= (force_rel & ~own_is1) | (blk0_q & m0_lock);
            blk1_q <= (force_rel & own_is1) | (blk1_q & m1_lock);
        end
    end
`else
    assign force_rel = 1'b0;
    assign elig0     = m0_req;
    assign elig1     = m1_req;
    assign lock_err  = 1'b0;
`endif

    // Current owner's view and the competing master, used by the owned-state transitions.
    always_comb begin
        own_is1  = (state_q == StOwn1);
        own_req  = own_is1 ? m1_req  : m0_req;
        own_lock = own_is1 ? m1_lock : m0_lock;
        own_gnt  = gnt0 | gnt1;
        oth_req  = own_is1 ? elig0   : elig1;
        st_oth   = own_is1 ? StOwn0  : StOwn1;
    end

    // Memory port follows the granted master; quiet and zeroed otherwise. Write beats read.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_rd    = m0_rd & ~m0_wr;
            mem_wr    = m0_wr;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_rd    = m1_rd & ~m1_wr;
            mem_wr    = m1_wr;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Ownership FSM with round-robin, lock/burst cap and read-return tagging.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_last_q   <= 1'b1;
            burst_cnt_q <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            // Tag follows the issuing master, independent of later ownership changes.
            m0_rvalid_q <= gnt0 & m0_rd & ~m0_wr;
            m1_rvalid_q <= gnt1 & m1_rd & ~m1_wr;
            case (state_q)
                StIdle: begin
                    burst_cnt_q <= '0;
                    if (elig0 && elig1) begin
                        state_q   <= rr_last_q ? StOwn0 : StOwn1;
                        rr_last_q <= ~rr_last_q;
                    end else if (elig0) begin
                        state_q   <= StOwn0;
                        rr_last_q <= 1'b0;
                    end else if (elig1) begin
                        state_q   <= StOwn1;
                        rr_last_q <= 1'b1;
                    end
                end
                StOwn0, StOwn1: begin
                    if (force_rel) begin
                        state_q     <= StIdle;
                        burst_cnt_q <= '0;
                    end else if (own_lock && oth_req && own_gnt && burst_cnt_q == BurstLast) begin
                        state_q     <= st_oth;
                        rr_last_q   <= ~own_is1;
                        burst_cnt_q <= '0;
                    end else if (own_lock) begin
                        // Saturate so a waiting master is still let in at the cap.
                        if (own_gnt && burst_cnt_q != BurstLast) begin
                            burst_cnt_q <= burst_cnt_q + 1'b1;
                        end
                    end else if (oth_req) begin
                        state_q     <= st_oth;
                        rr_last_q   <= ~own_is1;
                        burst_cnt_q <= '0;
                    end else if (own_req) begin
                        burst_cnt_q <= '0;
                    end else begin
                        state_q     <= StIdle;
                        burst_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign owner     = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a master-indexed
// behavioural model of the arbiter and a shadow copy of a small backing memory.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BM = 8;
    localparam int TO = 16;
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_lock, m0_rd, m0_wr;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_lock, m1_rd, m1_wr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    owner;
    logic          lock_err;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .BURST_MAX(BM), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .lock_err(lock_err)
    );

    // Small backing memory with registered read data; a preload port fills it during reset.
    logic [DW-1:0] mem_arr [16];
    logic          pl_en;
    logic [3:0]    pl_idx;
    logic [DW-1:0] pl_val;

    always @(posedge clk) begin
        if (pl_en) mem_arr[pl_idx] <= pl_val;
        else if (mem_wr) mem_arr[mem_addr[5:2]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem_arr[mem_addr[5:2]];
    end

    // Reference model state: owner as 0 idle / 1 M0 / 2 M1, master indices elsewhere.
    int            m_own;
    int            m_rr;
    int            m_burst;
    int            m_idle;
    bit            m_blk [2];
    bit            m_err;
    bit            m_rv [2];
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [16];

    int n_checks;
    int n_pass;

    int t2_exp [6] = '{0, 1, 2, 1, 2, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] fill(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    task automatic model_reset();
        m_own = 0; m_rr = 1; m_burst = 0; m_idle = 0; m_err = 0;
        m_blk[0] = 0; m_blk[1] = 0; m_rv[0] = 0; m_rv[1] = 0;
    endtask

    // One clock: check the combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit            req [2], lock [2], rd [2], wr [2], elig [2], g [2], n_blk [2], n_rv [2];
        logic [AW-1:0] addr [2];
        logic [DW-1:0] wd [2];
        logic [DW-1:0] n_rdata;
        logic          e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        int            x, o, n_own, n_rr, n_burst, n_idle;
        bit            n_err, frc;
        #1;
        req[0] = m0_req;   req[1] = m1_req;
        lock[0] = m0_lock; lock[1] = m1_lock;
        rd[0] = m0_rd;     rd[1] = m1_rd;
        wr[0] = m0_wr;     wr[1] = m1_wr;
        addr[0] = m0_addr; addr[1] = m1_addr;
        wd[0] = m0_wdata;  wd[1] = m1_wdata;
        e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0; n_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            g[i] = (m_own == i + 1) && req[i];
            elig[i] = req[i] && !m_blk[i];
            n_rv[i] = g[i] && rd[i] && !wr[i];
            if (g[i]) begin
                e_rd = rd[i] && !wr[i]; e_wr = wr[i]; e_addr = addr[i]; e_wd = wd[i];
                if (n_rv[i]) n_rdata = ref_mem[addr[i][5:2]];
                if (wr[i]) ref_mem[addr[i][5:2]] = wd[i];
            end
        end
        check("m0_gnt", 64'(m0_gnt), 64'(g[0]));
        check("m1_gnt", 64'(m1_gnt), 64'(g[1]));
        check("mem_rd", 64'(mem_rd), 64'(e_rd));
        check("mem_wr", 64'(mem_wr), 64'(e_wr));
        check("mem_addr", 64'(mem_addr), 64'(e_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(e_wd));

        n_own = m_own; n_rr = m_rr; n_burst = m_burst; n_idle = 0; n_err = 0; frc = 0;
        n_blk[0] = m_blk[0]; n_blk[1] = m_blk[1];
        if (m_own == 0) begin
            n_burst = 0;
            if (elig[0] && elig[1]) n_own = (m_rr == 1) ? 1 : 2;
            else if (elig[0]) n_own = 1;
            else if (elig[1]) n_own = 2;
        end else begin
            x = m_own - 1;
            o = 1 - x;
            if (TO_EN && lock[x] && !req[x]) begin
                if (m_idle + 1 >= TO) frc = 1;
                else n_idle = m_idle + 1;
            end
            if (frc) begin
                n_own = 0; n_err = 1; n_blk[x] = 1;
            end else if (lock[x] && elig[o] && g[x] && m_burst == BM - 1) begin
                n_own = o + 1;
            end else if (lock[x]) begin
                if (g[x] && m_burst < BM - 1) n_burst = m_burst + 1;
            end else if (elig[o]) begin
                n_own = o + 1;
            end else if (req[x]) begin
                n_burst = 0;
            end else begin
                n_own = 0;
            end
            if (n_own != m_own) n_burst = 0;
        end
        if (n_own != 0 && n_own != m_own) n_rr = n_own - 1;
        for (int i = 0; i < 2; i++) if (!lock[i]) n_blk[i] = 0;

        m_own = n_own; m_rr = n_rr; m_burst = n_burst; m_idle = n_idle; m_err = n_err;
        m_blk[0] = n_blk[0]; m_blk[1] = n_blk[1];
        m_rv[0] = n_rv[0]; m_rv[1] = n_rv[1]; m_rdata = n_rdata;
        if (reset) model_reset();

        @(posedge clk);
        #1;
        check("owner", 64'(owner), 64'(m_own));
        check("m0_rvalid", 64'(m0_rvalid), 64'(m_rv[0]));
        check("m1_rvalid", 64'(m1_rvalid), 64'(m_rv[1]));
        check("lock_err", 64'(lock_err), 64'(m_err));
        if (m_rv[0]) check("m0_rdata", 64'(m0_rdata), 64'(m_rdata));
        if (m_rv[1]) check("m1_rdata", 64'(m1_rdata), 64'(m_rdata));
    endtask

    task automatic drv0(input bit req, input bit lock, input bit rd, input bit wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m0_req = req; m0_lock = lock; m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic drv1(input bit req, input bit lock, input bit rd, input bit wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m1_req = req; m1_lock = lock; m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic clr();
        drv0(0, 0, 0, 0, '0, '0);
        drv1(0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int p0, p1;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        pl_en    = 1'b0;
        pl_idx   = '0;
        pl_val   = '0;
        clr();

        // Preload the memory while the arbiter is held in reset.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            pl_en = 1'b1; pl_idx = 4'(i); pl_val = fill(i); ref_mem[i] = fill(i);
        end
        @(posedge clk);
        #1;
        pl_idx = 4'd4; pl_val = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        model_reset();

        // Reset state.
        check("rst_owner", 64'(owner), 64'(0));
        check("rst_m0_gnt", 64'(m0_gnt), 64'(0));
        check("rst_m1_gnt", 64'(m1_gnt), 64'(0));
        check("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(0));
        check("rst_mem_rdwr", 64'({mem_rd, mem_wr}), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_lock_err", 64'(lock_err), 64'(0));
        reset = 1'b0;

        // First read from idle: grant one cycle after req, data the cycle after that.
        drv0(1, 0, 1, 0, 32'h10, '0);
        step();
        check("t1_owner", 64'(owner), 64'(1));
        #1;
        check("t1_gnt", 64'(m0_gnt), 64'(1));
        check("t1_mem_rd", 64'(mem_rd), 64'(1));
        step();
        check("t1_rvalid", 64'(m0_rvalid), 64'(1));
        check("t1_rdata", 64'(m0_rdata), 64'(32'hDEAD_BEEF));
        clr();
        step();

        // Both unlocked from idle: alternate with no bubble.
        do_reset();
        drv0(1, 0, 1, 0, 32'h100, '0);
        drv1(1, 0, 1, 0, 32'h204, '0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t2_m0_gnt", 64'(m0_gnt), 64'(t2_exp[i] == 1));
            check("t2_m1_gnt", 64'(m1_gnt), 64'(t2_exp[i] == 2));
            check("t2_mem_addr", 64'(mem_addr),
                  64'((t2_exp[i] == 1) ? 32'h100 : (t2_exp[i] == 2) ? 32'h204 : 32'h0));
            step();
        end
        clr();
        step();

        // Locked M1 burst capped at BM grants while M0 waits.
        do_reset();
        drv1(1, 1, 0, 1, 32'h3C, 32'h1234_5678);
        step();
        drv0(1, 0, 1, 0, 32'h300, '0);
        for (int i = 0; i < BM; i++) begin
            #1;
            check("t3_m1_gnt", 64'(m1_gnt), 64'(1));
            check("t3_m0_wait", 64'(m0_gnt), 64'(0));
            m1_wdata = 32'(i);
            step();
        end
        check("t3_owner", 64'(owner), 64'(1));
        #1;
        check("t3_m0_gnt", 64'(m0_gnt), 64'(1));
        step();
        clr();
        step();

        // Read return follows the issuer across an ownership change.
        do_reset();
        drv0(1, 0, 1, 0, 32'h20, '0);
        step();
        drv1(1, 0, 1, 0, 32'h24, '0);
        #1;
        check("t4_m0_gnt", 64'(m0_gnt), 64'(1));
        step();
        check("t4_owner", 64'(owner), 64'(2));
        check("t4_m0_rvalid", 64'(m0_rvalid), 64'(1));
        check("t4_m1_rvalid", 64'(m1_rvalid), 64'(0));
        check("t4_rdata", 64'(m0_rdata), 64'(fill(8)));
        clr();
        step();

        // Lock held with no request while M1 waits.
        do_reset();
        drv0(1, 1, 0, 0, 32'h0, '0);
        drv1(1, 0, 0, 1, 32'h3C, 32'hCAFE_0001);
        step();
        #1;
        check("t5_m0_gnt", 64'(m0_gnt), 64'(1));
        step();
        m0_req = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            step();
            check("t5_no_err", 64'(lock_err), 64'(0));
            check("t5_held", 64'(owner), 64'(1));
        end
        step();
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
        check("t5_err", 64'(lock_err), 64'(1));
        check("t5_released", 64'(owner), 64'(0));
        step();
        check("t5_err_pulse", 64'(lock_err), 64'(0));
        check("t5_m1_owner", 64'(owner), 64'(2));
        #1;
        check("t5_m1_gnt", 64'(m1_gnt), 64'(1));
`else
        check("t5_err", 64'(lock_err), 64'(0));
        check("t5_still_held", 64'(owner), 64'(1));
        step();
        check("t5_still_held2", 64'(owner), 64'(1));
        #1;
        check("t5_m1_starved", 64'(m1_gnt), 64'(0));
`endif
        clr();
        step();

        // Reset mid-burst drops ownership and the pending read.
        do_reset();
        drv1(1, 1, 0, 1, 32'h38, 32'h5555_AAAA);
        step();
        step();
        step();
        m1_rd = 1'b1;
        m1_wr = 1'b0;
        #1;
        check("t6_m1_gnt", 64'(m1_gnt), 64'(1));
        reset = 1'b1;
        step();
        check("t6_owner", 64'(owner), 64'(0));
        check("t6_gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
        check("t6_rvalid", 64'(m1_rvalid), 64'(0));
        check("t6_mem_wr", 64'(mem_wr), 64'(0));
        reset = 1'b0;
        clr();
        step();

        // Randomized traffic with sticky locks and per-segment request densities.
        p0 = 3;
        p1 = 3;
        for (int c = 0; c < 1200; c++) begin
            if (c % 50 == 0) begin
                p0 = int'($urandom_range(0, 4));
                p1 = int'($urandom_range(0, 4));
            end
            reset = ($urandom_range(0, 99) == 0);
            m0_req = (int'($urandom_range(0, 3)) < p0);
            m1_req = (int'($urandom_range(0, 3)) < p1);
            if ($urandom_range(0, 7) == 0) m0_lock = ~m0_lock;
            if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;
            m0_rd = ($urandom_range(0, 1) == 1);
            m1_rd = ($urandom_range(0, 1) == 1);
            m0_wr = ($urandom_range(0, 2) == 0);
            m1_wr = ($urandom_range(0, 2) == 0);
            m0_addr = $urandom & 32'hFFFF_FFFC;
            m1_addr = $urandom & 32'hFFFF_FFFC;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter sharing the single-port data memory.
- Master 0 is the CPU data port. Master 1 is the UART load/DMA engine.
- Round-robin ownership with lock (burst) support and a burst cap. Sits between the masters and the DataMem port; the peripheral decode stays in the CPU top.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- BURST_MAX, 8, maximum consecutive locked transfers granted while the other master waits.
- TIMEOUT, 16, idle-lock cycles before forced release (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 transfer request.
- m0_lock  in  1  master 0 holds ownership across transfers.
- m0_rd  in  1  master 0 read strobe, qualified by m0_req.
- m0_wr  in  1  master 0 write strobe, qualified by m0_req.
- m0_addr  in  AW  master 0 byte address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  transfer accepted this cycle.
- m0_rvalid  out  1  read data valid for master 0.
- m0_rdata  out  DW  read data (copy of mem_rdata).
- m1_req, m1_lock, m1_rd, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, registered, 1-cycle latency.
- owner  out  2  00 idle, 01 M0, 10 M1.
- lock_err  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset values: state IDLE; owner=00; rr_last=1 (M0 wins the first tie); burst_cnt=0; all gnt, rvalid, mem_rd, mem_wr and lock_err =0; mem_addr and mem_wdata =0.
- States: IDLE, OWN0, OWN1.
- gnt_x = (state==OWNx) & mx_req, combinational.
- When gnt_x=1, mem_rd/mem_wr/mem_addr/mem_wdata are driven combinationally from master x. Otherwise mem_rd=mem_wr=0 and addr/wdata hold 0.
- Simultaneous mx_rd & mx_wr is illegal: the write wins and no rvalid is produced.
- IDLE: no request stays in IDLE. One request goes to that master's OWN state. Both requesting goes to the master != rr_last. The first grant therefore comes one cycle after req rises from IDLE.
- OWNx, on the cycle it is entered: rr_last<=x, burst_cnt<=0.
- OWNx transitions, first match wins:
  - mx_lock=1, other master requesting, burst_cnt==BURST_MAX-1 with gnt_x=1: go to OWN(other).
  - mx_lock=1: stay in OWNx.
  - Other master requesting: go to OWN(other) directly, with no IDLE bubble.
  - mx_req=1: stay in OWNx.
  - Otherwise: go to IDLE.
- burst_cnt increments on each gnt_x while locked. It resets on an ownership change or when lock drops.
- Unlocked owner with both masters requesting: the grants alternate every cycle.
- Read return: rvalid_x is registered, asserting exactly 1 cycle after a granted read by master x. It goes to the issuing master even if ownership changed meanwhile. rdata goes to both masters; rvalid is the qualifier.
- Lock held with req low: ownership is kept and the other master is starved. Bound this with the optional feature.
- Reset asserted mid-transfer: every output returns to its reset value next edge. A pending rvalid is dropped.

Optional Feature:
- Macro DMEM_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A counter of consecutive cycles with state==OWNx, mx_lock=1 and mx_req=0.
  - At TIMEOUT the arbiter forces IDLE and pulses lock_err for 1 cycle.
  - The owner may not regain the grant until its lock drops.
  - The counter clears on any gnt_x.
- Undefined: no counter exists, lock is honoured indefinitely, and lock_err is tied to 0.

Test Plan:
- Reset, then m0_req=1 rd at addr 0x10 with mem returning 0xDEADBEEF:
  - cycle 1: owner=01, m0_gnt=1, mem_rd=1.
  - cycle 2: m0_rvalid=1, m0_rdata=0xDEADBEEF.
- Both masters req unlocked from IDLE for 6 cycles: grants go M0, M1, M0, M1, M0 with no idle cycle between them; mem_addr follows the granted master.
- M1 locked with continuous writes, M0 requesting, BURST_MAX=8: M1 gets exactly 8 grants, then owner=01 the following cycle, M0 granted.
- M0 read granted in cycle N, M1 takes ownership in cycle N+1: m0_rvalid=1 and m1_rvalid=0 in cycle N+1.
- With DMEM_ARB_LOCK_TIMEOUT_EN, TIMEOUT=16: M0 lock=1, req=0 for 16 cycles → lock_err pulses once, owner=00, then M1 granted next cycle. Without the macro, owner stays 01.
- reset pulsed while M1 is mid-burst → next edge: owner=00, all gnt=0, rvalid=0, mem_wr=0.
